crt_pixel_fetch: RTL
====================

# crt_pixel_fetch

Display-side pixel fetch stage that sits directly downstream of the `crt` timing generator. It consumes the generator's `ven`, `hs`, `vs` and `pixaddr`, issues word reads to the frame-buffer memory port ahead of use, and delays the sync/enable strobes by a fixed `LATENCY` so returned pixel data lines up with them. The block emits one pixel per cycle when video is enabled. It substitutes a border colour and flags a sticky underrun when memory is late.

## Interface
- `PIX_BITS`, 16: bits per pixel.
- `WORD_BITS`, 64: memory word width; `PPW = WORD_BITS/PIX_BITS` pixels per word (power of two, ≥2).
- `LATENCY`, 8: fixed input-to-output delay in cycles (≥4).
- `FIFO_DEPTH`, 4: words of read credit; sizes both the request queue and the data queue (power of two).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ven`, `hs`, `vs`  in  1 each  timing strobes from `crt`.
- `pixaddr`  in  32  pixel index from `crt`.
- `border`  in  PIX_BITS  colour substituted on underrun.
- `underrun_clr`  in  1  clears `underrun`.
- `mem_req`  out  1  read request valid.
- `mem_addr`  out  32  word address, `pixaddr >> log2(PPW)`.
- `mem_ack`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid; returns in request order.
- `mem_rdata`  in  WORD_BITS  read data.
- `pix_out`  out  PIX_BITS  pixel; lane 0 = bits `[PIX_BITS-1:0]`.
- `pix_valid`, `hs_out`, `vs_out`  out  1 each  delayed strobes.
- `underrun`  out  1  sticky late-data flag.

## Operation
- **Reset values.** All outputs are 0. Credits are set to `FIFO_DEPTH`. Queues, the skip counter and the delay line are cleared.
- **New-word detect.** An input cycle is a *new word* when `ven` = 1 and either the previous cycle had `ven` = 0, or the word address differs from the last recorded word address.
- **Request issue.**
  - On a new word with credit > 0: push the word address into the request queue, decrement credit, and tag the delay-line entry `nw=1`.
  - On a new word with credit = 0: push nothing, tag the entry `miss=1`.
- **Memory handshake.**
  - `mem_req` is high while the request queue is non-empty; `mem_addr` is the queue head.
  - The head pops when `mem_req & mem_ack`.
  - `mem_addr` is held stable while `mem_req` is high and no ack has occurred.
- **Return path.**
  - If skip = 0, `mem_rvalid` pushes into the data queue.
  - If skip > 0, the returned word is discarded, skip is decremented, and one credit is returned.
- **Delay line.** `LATENCY` stages, each holding `{ven, hs, vs, lane, nw, miss}`, where `lane = pixaddr[log2(PPW)-1:0]`.
- **Output stage** (entry leaving the delay line):
  - `nw` with data queue non-empty: pop the head into the current-word register, return one credit, output the selected lane from the newly popped word.
  - `nw` with data queue empty: output `border`, set `underrun`, increment skip. The credit stays reserved until the late word is discarded.
  - `miss`: output `border`, set `underrun`.
  - Otherwise, with `ven`: output the lane from the current-word register.
  - Not `ven`: `pix_out` = 0.
- **Underrun flag.** `underrun` clears on `underrun_clr`; a set in the same cycle wins.
- **Simultaneous events.**
  - Credit reserve and return in the same cycle net to zero.
  - Either queue may push and pop in the same cycle.
  - The data queue cannot overflow, because credits bound it.

## Timing
- `pix_valid`, `hs_out` and `vs_out` equal `ven`, `hs` and `vs` delayed exactly `LATENCY` cycles.
- `mem_req` rises no earlier than the cycle after the new-word cycle T.
- Data is on time if `mem_rvalid` for that word is sampled at or before the edge ending cycle T+LATENCY-1. Otherwise the word underruns.
- All outputs are registered.
- Reset asserted mid-line: `mem_req`, `pix_valid` and `underrun` fall immediately and asynchronously. In-flight returns after reset are not tracked; the memory port is reset alongside.

## Structure
- Shared package/header `crt_defs` holds:
  - `PPW` and `LANE_BITS` derivation;
  - the delay-line entry field layout;
  - the credit and skip counter width, `$clog2(FIFO_DEPTH)+1`.
- One sub-module, `crt_sync_fifo` (parameterised width/depth, same-cycle push/pop, full/empty), instantiated twice: request queue and data queue.
- The delay line and output select stay inline.

## Test plan
- **Reset.** Hold `reset` = 0 with random inputs → all outputs 0, `mem_req` = 0. Release → 8 cycles of `ven` = 0 give `pix_valid` = 0.
- **Aligned line.** `pixaddr` 0x100–0x107 with `ven` = 1, `mem_ack` immediate, `rvalid` 2 cycles after ack.
  - `mem_addr` is 0x40 then 0x41.
  - `pix_valid` is high for 8 cycles starting 8 cycles after the first `ven`.
  - `pix_out` follows lanes 0,1,2,3,0,1,2,3.
- **Unaligned start.** `pixaddr` 0x102–0x105 → requests 0x40 then 0x41; first pixel is lane 2 of word 0x40 (bits 47:32).
- **Memory stall.** `mem_ack` low for 12 cycles on a line with `border` = 0xF800.
  - Affected pixels output 0xF800 and `underrun` = 1.
  - The late word is discarded and credit recovers to 4.
  - `underrun_clr` then clears the flag.
- **Credit exhaustion.** 6 consecutive new words with `mem_ack` withheld → 4 requests queued; 5th and 6th are tagged miss and output `border`.
- **Mid-line reset.** Pulse `reset` low while `mem_req` = 1 → `mem_req` drops the same cycle. The next line fetches correctly from credit 4.

Source files
------------

// File: rtl/crt_defs.sv
// Shared derivations for the CRT pixel fetch path: lane geometry, counter widths
// and the bit layout of one delay-line entry.
package crt_defs;

    function automatic int ppw_of(input int word_bits, input int pix_bits);
        return word_bits / pix_bits;
    endfunction

    function automatic int lane_bits_of(input int word_bits, input int pix_bits);
        return $clog2(word_bits / pix_bits);
    endfunction

    // Credits and skips both count up to FIFO_DEPTH inclusive.
    function automatic int cnt_bits_of(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

    // Delay-line entry, MSB to LSB: {ven, hs, vs, lane, nw, miss}
    localparam int DL_MISS = 0;
    localparam int DL_NW   = 1;
    localparam int DL_LANE = 2;

    function automatic int dl_vs(input int lane_bits);
        return DL_LANE + lane_bits;
    endfunction

    function automatic int dl_hs(input int lane_bits);
        return DL_LANE + lane_bits + 1;
    endfunction

    function automatic int dl_ven(input int lane_bits);
        return DL_LANE + lane_bits + 2;
    endfunction

    function automatic int dl_width(input int lane_bits);
        return DL_LANE + lane_bits + 3;
    endfunction

endpackage

// File: rtl/crt_sync_fifo.sv
// Single-clock FIFO with registered full/empty; push and pop may coincide.
module crt_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count, count_nxt;
    logic             wr, rd;

    assign wr        = push & ~full;
    assign rd        = pop & ~empty;
    assign count_nxt = count + CW'(wr) - CW'(rd);
    assign dout      = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (rd) rptr <= rptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/crt_pixel_fetch.sv
// Pixel fetch behind the crt timing generator: prefetches frame-buffer words on
// credit and realigns returned pixels with the sync strobes LATENCY cycles later.
module crt_pixel_fetch
    import crt_defs::*;
#(
    parameter int PIX_BITS   = 16,
    parameter int WORD_BITS  = 64,
    parameter int LATENCY    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ven,
    input  logic                 hs,
    input  logic                 vs,
    input  logic [31:0]          pixaddr,
    input  logic [PIX_BITS-1:0]  border,
    input  logic                 underrun_clr,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_rvalid,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic [PIX_BITS-1:0]  pix_out,
    output logic                 pix_valid,
    output logic                 hs_out,
    output logic                 vs_out,
    output logic                 underrun
);
    localparam int PPW       = ppw_of(WORD_BITS, PIX_BITS);
    localparam int LANE_BITS = lane_bits_of(WORD_BITS, PIX_BITS);
    localparam int CNT_BITS  = cnt_bits_of(FIFO_DEPTH);
    localparam int DLW       = dl_width(LANE_BITS);
    // The registered output stage is the last of the LATENCY stages.
    localparam int NSTG      = LATENCY - 1;

    logic [31:0]          waddr, last_waddr;
    logic [LANE_BITS-1:0] lane_in;
    logic                 prev_ven, new_word, issue, miss_in;
    logic [CNT_BITS-1:0]  credit, credit_nxt, skip, skip_nxt;
    logic                 rq_empty, rq_full;
    logic                 dq_push, dq_pop, dq_empty, dq_full;
    logic [WORD_BITS-1:0] dq_head, fetch_word, cur_word, sel_word;
    logic                 rx_data, rx_skip;
    logic [DLW-1:0]       dl [NSTG];
    logic [DLW-1:0]       dl_in, ent;
    logic                 o_ven, o_hs, o_vs, o_nw, o_miss;
    logic [LANE_BITS-1:0] o_lane;
    logic                 data_avail, take, late, bypass;
    logic [PPW-1:0][PIX_BITS-1:0] lanes;
    logic [PIX_BITS-1:0]  pix_nxt;
    logic                 ur_nxt;

    assign waddr    = pixaddr >> LANE_BITS;
    assign lane_in  = pixaddr[LANE_BITS-1:0];
    assign new_word = ven & (~prev_ven | (waddr != last_waddr));
    assign issue    = new_word & (credit != '0) & ~rq_full;
    assign miss_in  = new_word & ~issue;
    assign dl_in    = {ven, hs, vs, lane_in, issue, miss_in};

    assign mem_req = ~rq_empty;

    crt_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_req_q (
        .clk   (clk),
        .reset (reset),
        .push  (issue),
        .din   (waddr),
        .pop   (mem_req & mem_ack),
        .dout  (mem_addr),
        .full  (rq_full),
        .empty (rq_empty)
    );

    // Words for entries that already gave up on them are dropped, not queued.
    assign rx_skip = mem_rvalid & (skip != '0);
    assign rx_data = mem_rvalid & (skip == '0);

    assign ent    = dl[NSTG-1];
    assign o_ven  = ent[dl_ven(LANE_BITS)];
    assign o_hs   = ent[dl_hs(LANE_BITS)];
    assign o_vs   = ent[dl_vs(LANE_BITS)];
    assign o_lane = ent[DL_LANE +: LANE_BITS];
    assign o_nw   = ent[DL_NW];
    assign o_miss = ent[DL_MISS];

    // A word arriving in the very cycle it is needed is taken straight off the bus.
    assign data_avail = ~dq_empty | rx_data;
    assign take       = o_nw & data_avail;
    assign late       = o_nw & ~data_avail;
    assign bypass     = take & dq_empty;
    assign dq_push    = rx_data & ~bypass & ~dq_full;
    assign dq_pop     = take & ~dq_empty;
    assign fetch_word = dq_empty ? mem_rdata : dq_head;
    assign sel_word   = take ? fetch_word : cur_word;
    assign lanes      = sel_word;

    crt_sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_data_q (
        .clk   (clk),
        .reset (reset),
        .push  (dq_push),
        .din   (mem_rdata),
        .pop   (dq_pop),
        .dout  (dq_head),
        .full  (dq_full),
        .empty (dq_empty)
    );

    assign credit_nxt = credit - CNT_BITS'(issue) + CNT_BITS'(take) + CNT_BITS'(rx_skip);
    assign skip_nxt   = skip + CNT_BITS'(late) - CNT_BITS'(rx_skip);

    always_comb begin
        pix_nxt = '0;
        ur_nxt  = underrun;
        if (underrun_clr) ur_nxt = 1'b0;
        if (late || o_miss) ur_nxt = 1'b1;
        if (o_ven) pix_nxt = (late || o_miss) ? border : lanes[o_lane];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_ven   <= 1'b0;
            last_waddr <= '0;
            credit     <= CNT_BITS'(FIFO_DEPTH);
            skip       <= '0;
            cur_word   <= '0;
            for (int i = 0; i < NSTG; i++) dl[i] <= '0;
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            prev_ven <= ven;
            if (ven) last_waddr <= waddr;
            credit <= credit_nxt;
            skip   <= skip_nxt;
            if (take) cur_word <= fetch_word;
            dl[0] <= dl_in;
            for (int i = 1; i < NSTG; i++) dl[i] <= dl[i-1];
            pix_out   <= pix_nxt;
            pix_valid <= o_ven;
            hs_out    <= o_hs;
            vs_out    <= o_vs;
            underrun  <= ur_nxt;
        end
    end

endmodule
